fir_coef_ctrl: RTL and testbench
================================

# fir_coef_ctrl

Run-time coefficient controller for the 21-tap symmetric FIR in the audio sample path. A host writes a new coefficient set into a shadow bank over a simple write port, then requests a commit. The block copies the shadow bank to the active bank only on a sample boundary, so the FIR never computes one output with a mix of old and new taps. The active bank drives the FIR coefficient inputs directly as a flat bus.

## Interface
Parameters:
- NTAP, 21, number of taps (odd).
- CW, 16, coefficient width, signed two's complement.
- AW, 5, address width, ceil(log2(NTAP)).
- SYM_CHECK, 1, when 1 a commit is rejected unless the shadow bank is symmetric.

Ports:
- clk_100k  in  1  sample-rate clock.
- rst_n  in  1  reset, asynchronous, active-low.
- samp_stb  in  1  one-cycle pulse on the cycle a new sample enters the FIR delay line.
- cfg_wr  in  1  write strobe into the shadow bank.
- cfg_addr  in  AW  tap index for write and readback.
- cfg_wdata  in  CW  coefficient to write.
- cfg_rsel  in  1  readback source: 0 = active bank, 1 = shadow bank.
- cfg_commit  in  1  commit request pulse.
- cfg_rdata  out  CW  registered readback of bank[cfg_addr].
- cfg_busy  out  1  high while a commit is pending.
- cfg_err  out  1  one-cycle error pulse.
- commit_done  out  1  one-cycle pulse on the cycle after the copy.
- gen_cnt  out  8  commit generation counter.
- coef_bus  out  NTAP*CW  active coefficients; tap k sits at [k*CW +: CW].

## Operation
- Reset values:
  - Active and shadow banks both load DEFAULT_COEF: the symmetric low-pass set, tap0 = 16'h0312, tap1 = 16'h03F8, center tap10 = 16'h28E9.
  - gen_cnt = 0, cfg_rdata = 0, cfg_busy = 0, cfg_err = 0, commit_done = 0.
- FSM states: IDLE, PEND.
- IDLE + cfg_commit:
  - With SYM_CHECK = 1 and shadow[k] != shadow[NTAP-1-k] for any k: pulse cfg_err and stay in IDLE.
  - Otherwise go to PEND.
- PEND + samp_stb: copy active <= shadow in a single cycle, increment gen_cnt (wraps 255 -> 0), return to IDLE.
- Writes:
  - cfg_wr with cfg_addr < NTAP updates the shadow bank at the next edge, in either state.
  - A write during PEND is included in the pending copy, including a write on the copy cycle itself.
  - cfg_wr with cfg_addr >= NTAP is dropped and pulses cfg_err.
- Simultaneous events:
  - cfg_commit during PEND is ignored (no error, no second copy).
  - cfg_commit and samp_stb in the same IDLE cycle: move to PEND and wait for the next samp_stb, never that one.
  - A commit with no intervening writes is legal: it copies identical data and gen_cnt still increments.
  - The symmetry check sees the shadow bank as it stood before a cfg_wr in the same cycle.
- Readback: cfg_rdata registers bank[cfg_addr] selected by cfg_rsel. An out-of-range address returns 0 with no error.
- Reset mid-PEND: the pending commit is dropped and both banks return to DEFAULT_COEF.

## Timing
- Shadow write latency: 1 cycle.
- Readback latency: 1 cycle.
- Commit request to PEND: 1 edge; cfg_busy goes high after that edge.
- Copy:
  - coef_bus changes at the edge where PEND and samp_stb are both high.
  - The FIR therefore uses the new taps for the product of the sample latched at that same edge.
  - commit_done and the new gen_cnt are visible after that edge; cfg_busy falls at the same edge.
- Worst-case commit latency: one sample period plus 1 cycle.
- cfg_err: asserts 1 cycle after the offending request and lasts exactly 1 cycle.
- coef_bus is glitch-free: it is driven only from active-bank registers.

## Structure
- Shared package fir_pkg holds:
  - NTAP, CW, AW.
  - DEFAULT_COEF, the constant array of 21 values.
  - The FSM state enum (IDLE, PEND).
- Natural sub-module: fir_coef_bank, an NTAP x CW register file with a reset-to-constant, one write port, a full parallel copy-in port and a flat output bus. It is instantiated twice, once for shadow and once for active.
- Control FSM, symmetry comparator (floor(NTAP/2) pair compares), readback mux and gen_cnt live in the top level.

## Test plan
- Reset → coef_bus tap0 = 0x0312 and tap10 = 0x28E9; gen_cnt = 0; cfg_busy = 0.
- Write a symmetric set with tap10 = 0x4000 and all other taps 0, commit, samp_stb 7 cycles later → coef_bus unchanged until that edge, then tap10 = 0x4000; commit_done pulses once; gen_cnt = 1.
- SYM_CHECK = 1, write tap3 = 0x1111 only, commit → cfg_err pulses; state stays IDLE; coef_bus unchanged.
- cfg_commit and samp_stb in the same cycle → no copy at that strobe; copy happens at the following samp_stb.
- cfg_wr to addr 25 → cfg_err pulses; readback of addr 0..20 with cfg_rsel = 1 is unchanged.
- Assert rst_n low during PEND after writing tap10 = 0x4000 → after reset, shadow and active tap10 both read 0x28E9 and cfg_busy = 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, default coefficient set and controller state type for the
// run-time FIR coefficient controller.
package fir_pkg;

    localparam int unsigned NTAP = 21;
    localparam int unsigned CW   = 16;
    localparam int unsigned AW   = 5;

    // Symmetric low-pass set loaded into both banks at reset.
    localparam logic [CW-1:0] DEFAULT_COEF [NTAP] = '{
        16'h0312, 16'h03F8, 16'h04C2, 16'h0611, 16'h07A5, 16'h0976, 16'h0B73,
        16'h0D8A, 16'h0FA3, 16'h11A4, 16'h28E9, 16'h11A4, 16'h0FA3, 16'h0D8A,
        16'h0B73, 16'h0976, 16'h07A5, 16'h0611, 16'h04C2, 16'h03F8, 16'h0312
    };

    typedef enum logic {
        StIdle,
        StPend
    } ctrl_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// NTAP x CW coefficient register file: resets to the default set, one write port,
// a full parallel copy-in port and a flat output bus.
module fir_coef_bank #(
    parameter int unsigned NTAP = fir_pkg::NTAP,
    parameter int unsigned CW   = fir_pkg::CW,
    parameter int unsigned AW   = fir_pkg::AW
) (
    input  logic               clk_100k,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [CW-1:0]      wr_data_i,
    input  logic               cpy_en_i,
    input  logic [NTAP*CW-1:0] cpy_data_i,
    output logic [NTAP*CW-1:0] bus_o
);
    import fir_pkg::*;

    logic [CW-1:0] mem_q [NTAP];
    logic [CW-1:0] mem_d [NTAP];

    always_comb begin
        for (int k = 0; k < int'(NTAP); k++) begin
            mem_d[k] = mem_q[k];
            if (cpy_en_i) begin
                mem_d[k] = cpy_data_i[k*CW +: CW];
            end
            if (wr_en_i && (wr_addr_i == AW'(k))) begin
                mem_d[k] = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_100k or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NTAP); k++) begin
                mem_q[k] <= CW'(DEFAULT_COEF[k]);
            end
        end else begin
            for (int k = 0; k < int'(NTAP); k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    always_comb begin
        bus_o = '0;
        for (int k = 0; k < int'(NTAP); k++) begin
            bus_o[k*CW +: CW] = mem_q[k];
        end
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Shadow/active coefficient controller: host writes the shadow bank, a commit copies
// it to the active bank on the next sample strobe so no output mixes old and new taps.
module fir_coef_ctrl #(
    parameter int unsigned NTAP      = fir_pkg::NTAP,
    parameter int unsigned CW        = fir_pkg::CW,
    parameter int unsigned AW        = fir_pkg::AW,
    parameter bit          SYM_CHECK = 1'b1
) (
    input  logic               clk_100k,
    input  logic               rst_n,
    input  logic               samp_stb_i,
    input  logic               cfg_wr_i,
    input  logic [AW-1:0]      cfg_addr_i,
    input  logic [CW-1:0]      cfg_wdata_i,
    input  logic               cfg_rsel_i,
    input  logic               cfg_commit_i,
    output logic [CW-1:0]      cfg_rdata_o,
    output logic               cfg_busy_o,
    output logic               cfg_err_o,
    output logic               commit_done_o,
    output logic [7:0]         gen_cnt_o,
    output logic [NTAP*CW-1:0] coef_bus_o
);
    import fir_pkg::*;

    ctrl_state_e        state_q, state_d;
    logic [NTAP*CW-1:0] shadow_bus, active_bus, shadow_nxt;
    logic               addr_ok, sym_ok, copy, sym_err;
    logic               err_q, err_d;
    logic               done_q;
    logic [7:0]         gen_q, gen_d;
    logic [CW-1:0]      rdata_q, rdata_d;

    assign addr_ok = (32'(cfg_addr_i) < NTAP);

    fir_coef_bank #(
        .NTAP (NTAP),
        .CW   (CW),
        .AW   (AW)
    ) u_shadow (
        .clk_100k   (clk_100k),
        .rst_n      (rst_n),
        .wr_en_i    (cfg_wr_i & addr_ok),
        .wr_addr_i  (cfg_addr_i),
        .wr_data_i  (cfg_wdata_i),
        .cpy_en_i   (1'b0),
        .cpy_data_i ('0),
        .bus_o      (shadow_bus)
    );

    fir_coef_bank #(
        .NTAP (NTAP),
        .CW   (CW),
        .AW   (AW)
    ) u_active (
        .clk_100k   (clk_100k),
        .rst_n      (rst_n),
        .wr_en_i    (1'b0),
        .wr_addr_i  ('0),
        .wr_data_i  ('0),
        .cpy_en_i   (copy),
        .cpy_data_i (shadow_nxt),
        .bus_o      (active_bus)
    );

    // Copy source includes a write landing on the copy cycle itself.
    always_comb begin
        shadow_nxt = shadow_bus;
        for (int k = 0; k < int'(NTAP); k++) begin
            if (cfg_wr_i && (cfg_addr_i == AW'(k))) begin
                shadow_nxt[k*CW +: CW] = cfg_wdata_i;
            end
        end
    end

    always_comb begin
        sym_ok = 1'b1;
        for (int k = 0; k < int'(NTAP / 2); k++) begin
            if (shadow_bus[k*CW +: CW] != shadow_bus[(int'(NTAP) - 1 - k)*CW +: CW]) begin
                sym_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        sym_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A strobe in the commit cycle is deliberately not used for the copy.
                if (cfg_commit_i) begin
                    if (SYM_CHECK && !sym_ok) begin
                        sym_err = 1'b1;
                    end else begin
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                if (samp_stb_i) begin
                    copy    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_d   = sym_err | (cfg_wr_i & ~addr_ok);
        gen_d   = copy ? gen_q + 8'd1 : gen_q;
        rdata_d = '0;
        if (addr_ok) begin
            rdata_d = cfg_rsel_i ? shadow_bus[int'(cfg_addr_i)*CW +: CW]
                                 : active_bus[int'(cfg_addr_i)*CW +: CW];
        end
    end

    always_ff @(posedge clk_100k or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            gen_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            done_q  <= copy;
            gen_q   <= gen_d;
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata_o   = rdata_q;
    assign cfg_busy_o    = (state_q == StPend);
    assign cfg_err_o     = err_q;
    assign commit_done_o = done_q;
    assign gen_cnt_o     = gen_q;
    assign coef_bus_o    = active_bus;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: cycle model of both banks and the commit FSM,
// with expected commits queued when the copying strobe is driven.
module tb_fir_coef_ctrl;
    import fir_pkg::*;

    localparam int N  = int'(NTAP);
    localparam int BW = N * int'(CW);

    logic              clk_100k = 1'b0;
    logic              rst_n    = 1'b1;
    logic              samp_stb = 1'b0;
    logic              cfg_wr   = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [CW-1:0]     cfg_wdata = '0;
    logic              cfg_rsel = 1'b0;
    logic              cfg_commit = 1'b0;
    logic [CW-1:0]     cfg_rdata;
    logic              cfg_busy, cfg_err, commit_done;
    logic [7:0]        gen_cnt;
    logic [BW-1:0]     coef_bus;

    always #5 clk_100k = ~clk_100k;

    fir_coef_ctrl dut (
        .clk_100k      (clk_100k),
        .rst_n         (rst_n),
        .samp_stb_i    (samp_stb),
        .cfg_wr_i      (cfg_wr),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_rsel_i    (cfg_rsel),
        .cfg_commit_i  (cfg_commit),
        .cfg_rdata_o   (cfg_rdata),
        .cfg_busy_o    (cfg_busy),
        .cfg_err_o     (cfg_err),
        .commit_done_o (commit_done),
        .gen_cnt_o     (gen_cnt),
        .coef_bus_o    (coef_bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_seen    = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [BW-1:0] bus;
        logic [7:0]    gen;
    } commit_t;

    logic [CW-1:0] m_shadow [N];
    logic [CW-1:0] m_active [N];
    bit            m_pend;
    logic [7:0]    m_gen;
    commit_t       sb_q [$];

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = DEFAULT_COEF[k];
            m_active[k] = DEFAULT_COEF[k];
        end
        m_pend = 1'b0;
        m_gen  = 8'd0;
        sb_q.delete();
    endfunction

    function automatic logic [BW-1:0] flat_active();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < N; k++) b[k*CW +: CW] = m_active[k];
        return b;
    endfunction

    function automatic logic [BW-1:0] tap(input int k);
        return BW'(coef_bus[k*CW +: CW]);
    endfunction

    // One clock: predict from the inputs now driven, advance, then check every output.
    task automatic step();
        logic [CW-1:0] sh_n [N];
        logic [CW-1:0] exp_rd;
        bit            exp_err, exp_done, sym, pend_n;
        commit_t       c;
        sh_n     = m_shadow;
        pend_n   = m_pend;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        sym      = 1'b1;
        for (int k = 0; k < N / 2; k++) begin
            if (m_shadow[k] != m_shadow[N-1-k]) sym = 1'b0;
        end
        exp_rd = '0;
        if (int'(cfg_addr) < N) exp_rd = cfg_rsel ? m_shadow[cfg_addr] : m_active[cfg_addr];
        if (cfg_wr) begin
            if (int'(cfg_addr) < N) sh_n[cfg_addr] = cfg_wdata;
            else exp_err = 1'b1;
        end
        if (!m_pend) begin
            if (cfg_commit) begin
                if (!sym) exp_err = 1'b1;
                else pend_n = 1'b1;
            end
        end else if (samp_stb) begin
            c.bus = '0;
            for (int k = 0; k < N; k++) c.bus[k*CW +: CW] = sh_n[k];
            c.gen = m_gen + 8'd1;
            sb_q.push_back(c);
            exp_done = 1'b1;
            pend_n   = 1'b0;
        end
        @(posedge clk_100k);
        #1;
        if (!rst_n) begin
            model_reset();
            exp_rd   = '0;
            exp_err  = 1'b0;
            exp_done = 1'b0;
        end else begin
            m_shadow = sh_n;
            m_pend   = pend_n;
            if (exp_done) begin
                m_active = sh_n;
                m_gen    = m_gen + 8'd1;
            end
        end
        check("busy", BW'(cfg_busy), BW'(m_pend));
        check("err", BW'(cfg_err), BW'(exp_err));
        check("done", BW'(commit_done), BW'(exp_done));
        check("rdata", BW'(cfg_rdata), BW'(exp_rd));
        check("gen", BW'(gen_cnt), BW'(m_gen));
        check("coef_bus", coef_bus, flat_active());
        if (commit_done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", BW'(commit_done), '0);
            end else begin
                c = sb_q.pop_front();
                check("sb_bus", coef_bus, c.bus);
                check("sb_gen", BW'(gen_cnt), BW'(c.gen));
                done_seen++;
            end
        end
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        cfg_wr = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic commit(input bit stb);
        cfg_commit = 1'b1; samp_stb = stb;
        step();
        cfg_commit = 1'b0; samp_stb = 1'b0;
    endtask

    task automatic strobe();
        samp_stb = 1'b1;
        step();
        samp_stb = 1'b0;
    endtask

    task automatic rd(input int a, input bit sel);
        cfg_addr = AW'(a); cfg_rsel = sel;
        step();
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_tap0", tap(0), BW'(16'h0312));
        check("rst_tap10", tap(10), BW'(16'h28E9));
        check("rst_gen", BW'(gen_cnt), '0);
        check("rst_busy", BW'(cfg_busy), '0);

        // Center-only set, commit, strobe seven cycles later.
        for (int k = 0; k < N; k++) wr(k, (k == 10) ? 16'h4000 : 16'h0000);
        commit(1'b0);
        repeat (6) step();
        check("pend_tap10_old", tap(10), BW'(16'h28E9));
        strobe();
        check("copy_tap10", tap(10), BW'(16'h4000));
        check("copy_gen", BW'(gen_cnt), BW'(8'd1));
        check("copy_done_count", BW'(done_seen), BW'(1));
        step();

        // Asymmetric shadow is rejected.
        wr(3, 16'h1111);
        commit(1'b0);
        check("sym_err_pulse", BW'(cfg_err), BW'(1'b1));
        check("sym_err_idle", BW'(cfg_busy), '0);
        step();
        check("sym_err_clear", BW'(cfg_err), '0);

        // Commit coinciding with a strobe waits for the next one.
        wr(17, 16'h1111);
        commit(1'b1);
        check("same_cyc_busy", BW'(cfg_busy), BW'(1'b1));
        check("same_cyc_nocopy", tap(3), '0);
        repeat (3) step();
        strobe();
        check("next_stb_copy", tap(3), BW'(16'h1111));

        // Out-of-range write, then full shadow readback.
        wr(25, 16'hBEEF);
        check("oob_err", BW'(cfg_err), BW'(1'b1));
        for (int a = 0; a < N; a++) rd(a, 1'b1);
        rd(25, 1'b1);
        rd(10, 1'b0);

        // Writes during PEND and on the copy cycle; a second commit is ignored.
        commit(1'b0);
        wr(5, 16'h0AAA);
        commit(1'b0);
        cfg_wr = 1'b1; cfg_addr = AW'(15); cfg_wdata = 16'h0AAA; samp_stb = 1'b1;
        step();
        cfg_wr = 1'b0; samp_stb = 1'b0;
        check("copy_cycle_write", tap(15), BW'(16'h0AAA));
        check("pend_write", tap(5), BW'(16'h0AAA));

        // Commits with no writes still count; run the generation counter through its wrap.
        while (m_gen != 8'd255) begin
            commit(1'b0);
            strobe();
        end
        commit(1'b0);
        strobe();
        check("gen_wrap", BW'(gen_cnt), '0);

        // Reset while a commit is pending.
        wr(10, 16'h4000);
        commit(1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst_pend_busy", BW'(cfg_busy), '0);
        check("rst_pend_tap10", tap(10), BW'(16'h28E9));
        model_reset();
        step();
        rst_n = 1'b1;
        rd(10, 1'b1);
        rd(10, 1'b1);
        check("rst_shadow_tap10", BW'(cfg_rdata), BW'(16'h28E9));
        rd(10, 1'b0);
        rd(10, 1'b0);
        check("rst_active_tap10", BW'(cfg_rdata), BW'(16'h28E9));
        check("rst_busy_after", BW'(cfg_busy), '0);

        check("sb_left", BW'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
